// File: rtl/ula_multiciclo.sv
// ula_multiciclo: multi-cycle ALU with valid/accept handshake and iterative signed mult/div.
// Define ULA_HI_EN to drive resultado_hi with the mult high half / div remainder (tied 0 otherwise).
module ula_multiciclo #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               entrada_valida,
  output logic               ocupado,
  input  logic [3:0]         controle_ULA,
  input  logic [WIDTH-1:0]   dado_1,
  input  logic [WIDTH-1:0]   dado_ULA,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               saida_valida,
  input  logic               saida_aceita,
  output logic [WIDTH-1:0]   resultado_ULA,
  output logic [WIDTH-1:0]   resultado_hi,
  output logic               zero,
  output logic               cond,
  output logic               sobrecarga,
  output logic               erro_div
);

  typedef enum logic [1:0] {OCIOSO, CALCULA, PRONTO} estado_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'b0000, OP_MOVA = 4'b0001, OP_MOVB = 4'b0010, OP_NE   = 4'b0011,
    OP_ADD  = 4'b0100, OP_SUB  = 4'b0101, OP_MUL  = 4'b0110, OP_DIV  = 4'b0111,
    OP_AND  = 4'b1000, OP_OR   = 4'b1001, OP_NOTA = 4'b1010, OP_XOR  = 4'b1011,
    OP_EQ   = 4'b1100, OP_SLT  = 4'b1101, OP_SLL  = 4'b1110, OP_SRA  = 4'b1111
  } op_t;

  estado_t r_estado, w_prox;
  op_t     w_op;

  logic [WIDTH-1:0]   w_sum, w_dif, w_res, w_mag_a, w_mag_b, w_min;
  logic               w_cond, w_ovf, w_err, w_zero, w_iterativa;

  logic [WIDTH-1:0]   r_hi, r_lo, r_b;
  logic [SHAMT_W-1:0] r_cnt;
  logic               r_is_div, r_neg;
  logic [WIDTH-1:0]   r_res;
  logic               r_zero, r_cond, r_ovf, r_err;

  logic [WIDTH:0]     w_mul_sum, w_trial, w_sub;
  logic [WIDTH-1:0]   w_it_hi, w_it_lo, w_lo_fix;
  logic               w_qbit, w_ultimo;

  assign w_op    = op_t'(controle_ULA);
  assign w_min   = {1'b1, {(WIDTH-1){1'b0}}};
  assign w_sum   = dado_1 + dado_ULA;
  assign w_dif   = dado_1 - dado_ULA;
  assign w_mag_a = dado_1[WIDTH-1]   ? -dado_1   : dado_1;
  assign w_mag_b = dado_ULA[WIDTH-1] ? -dado_ULA : dado_ULA;

  always_comb begin
    w_res  = '0;
    w_cond = 1'b0;
    w_ovf  = 1'b0;
    w_err  = 1'b0;
    case (w_op)
      OP_MOVA: w_res = dado_1;
      OP_MOVB: w_res = dado_ULA;
      OP_ADD: begin
        w_res = w_sum;
        w_ovf = (dado_1[WIDTH-1] == dado_ULA[WIDTH-1]) && (w_sum[WIDTH-1] != dado_1[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_dif;
        w_ovf = (dado_1[WIDTH-1] != dado_ULA[WIDTH-1]) && (w_dif[WIDTH-1] != dado_1[WIDTH-1]);
      end
      OP_DIV: begin
        w_err = (dado_ULA == '0);
        w_ovf = (dado_1 == w_min) && (dado_ULA == '1);
      end
      OP_AND:  w_res = dado_1 & dado_ULA;
      OP_OR:   w_res = dado_1 | dado_ULA;
      OP_NOTA: w_res = ~dado_1;
      OP_XOR:  w_res = dado_1 ^ dado_ULA;
      OP_EQ:   w_cond = (dado_1 == dado_ULA);
      OP_NE:   w_cond = (dado_1 != dado_ULA);
      OP_SLT:  w_cond = ($signed(dado_1) < $signed(dado_ULA));
      OP_SLL:  w_res = dado_1 << shamt;
      OP_SRA:  w_res = $signed(dado_1) >>> shamt;
      default: w_res = '0;
    endcase
    if (w_op == OP_EQ || w_op == OP_NE || w_op == OP_SLT)
      w_res = {{(WIDTH-1){1'b0}}, w_cond};
    w_zero = (w_res == '0) && (w_op != OP_NOP);
  end

  // Divide by zero skips the iteration and completes like a single-cycle op.
  assign w_iterativa = (w_op == OP_MUL) || ((w_op == OP_DIV) && !w_err);

  // One iteration step: shift-add multiply on {r_hi,r_lo}, restoring divide with r_hi as remainder.
  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_trial   = {r_hi, r_lo[WIDTH-1]};
  assign w_sub     = w_trial - {1'b0, r_b};
  assign w_qbit    = ~w_sub[WIDTH];

  always_comb begin
    if (r_is_div) begin
      w_it_hi = w_qbit ? w_sub[WIDTH-1:0] : w_trial[WIDTH-1:0];
      w_it_lo = {r_lo[WIDTH-2:0], w_qbit};
    end else begin
      w_it_hi = w_mul_sum[WIDTH:1];
      w_it_lo = {w_mul_sum[0], r_lo[WIDTH-1:1]};
    end
  end

  // The low half of a negated product is the negated low half, so mult and div share this fix.
  assign w_lo_fix = r_neg ? -w_it_lo : w_it_lo;
  assign w_ultimo = (r_cnt == SHAMT_W'(WIDTH-1));

`ifdef ULA_HI_EN
  logic             r_negr;
  logic [WIDTH-1:0] r_hi_o, w_hi_fix;

  always_comb begin
    if (r_is_div)
      w_hi_fix = r_negr ? -w_it_hi : w_it_hi;
    else if (r_neg)
      w_hi_fix = ~w_it_hi + {{(WIDTH-1){1'b0}}, (w_it_lo == '0)};
    else
      w_hi_fix = w_it_hi;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_negr <= 1'b0;
      r_hi_o <= '0;
    end else if (r_estado == OCIOSO && entrada_valida) begin
      r_negr <= dado_1[WIDTH-1];
      r_hi_o <= '0;
    end else if (r_estado == CALCULA && w_ultimo) begin
      r_hi_o <= w_hi_fix;
    end
  end

  assign resultado_hi = r_hi_o;
`else
  assign resultado_hi = '0;
`endif

  always_ff @(posedge clock) begin
    if (!reset) r_estado <= OCIOSO;
    else        r_estado <= w_prox;
  end

  always_comb begin
    w_prox = r_estado;
    case (r_estado)
      OCIOSO:  if (entrada_valida) w_prox = w_iterativa ? CALCULA : PRONTO;
      CALCULA: if (w_ultimo)       w_prox = PRONTO;
      PRONTO:  if (saida_aceita)   w_prox = OCIOSO;
      default: w_prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg    <= 1'b0;
      r_res    <= '0;
      r_zero   <= 1'b0;
      r_cond   <= 1'b0;
      r_ovf    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_estado)
        OCIOSO: if (entrada_valida) begin
          r_hi     <= '0;
          r_lo     <= w_mag_a;
          r_b      <= w_mag_b;
          r_cnt    <= '0;
          r_is_div <= (w_op == OP_DIV);
          r_neg    <= dado_1[WIDTH-1] ^ dado_ULA[WIDTH-1];
          r_res    <= w_res;
          r_zero   <= w_zero;
          r_cond   <= w_cond;
          r_ovf    <= w_ovf;
          r_err    <= w_err;
        end
        CALCULA: begin
          r_hi  <= w_it_hi;
          r_lo  <= w_it_lo;
          r_cnt <= r_cnt + SHAMT_W'(1);
          if (w_ultimo) begin
            r_res  <= w_lo_fix;
            r_zero <= (w_lo_fix == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign ocupado       = (r_estado != OCIOSO);
  assign saida_valida  = (r_estado == PRONTO);
  assign resultado_ULA = r_res;
  assign zero          = r_zero;
  assign cond          = r_cond;
  assign sobrecarga    = r_ovf;
  assign erro_div      = r_err;

endmodule

// File: tb/tb_ula_multiciclo.sv
// Scoreboard bench for ula_multiciclo (WIDTH=32): directed vectors, monitor checks result, flags and latency.
module tb_ula_multiciclo;

  logic        clock = 1'b0;
  logic        reset;
  logic        entrada_valida;
  logic        ocupado;
  logic [3:0]  controle_ULA;
  logic [31:0] dado_1, dado_ULA;
  logic [4:0]  shamt;
  logic        saida_valida, saida_aceita;
  logic [31:0] resultado_ULA, resultado_hi;
  logic        zero, cond, sobrecarga, erro_div;

  ula_multiciclo #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .entrada_valida(entrada_valida), .ocupado(ocupado),
    .controle_ULA(controle_ULA), .dado_1(dado_1), .dado_ULA(dado_ULA), .shamt(shamt),
    .saida_valida(saida_valida), .saida_aceita(saida_aceita),
    .resultado_ULA(resultado_ULA), .resultado_hi(resultado_hi),
    .zero(zero), .cond(cond), .sobrecarga(sobrecarga), .erro_div(erro_div)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] res;
    logic [31:0] hi;
    logic        z, c, o, e;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  bit   got = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per new result, then checks it stays stable while held.
  always @(negedge clock) begin
    if (reset === 1'b1 && saida_valida === 1'b1) begin
      if (!got) begin
        got = 1'b1;
        if (q.size() == 0) begin
          chk("unexpected_valid", 64'd1, 64'd0);
        end else begin
          cur = q.pop_front();
          chk("res",     resultado_ULA, cur.res);
          chk("hi",      resultado_hi,  cur.hi);
          chk("zero",    zero,          cur.z);
          chk("cond",    cond,          cur.c);
          chk("ovf",     sobrecarga,    cur.o);
          chk("err",     erro_div,      cur.e);
          chk("latency", cyc - cur.acc + 1, cur.lat);
        end
      end else begin
        chk("hold_res",  resultado_ULA, cur.res);
        chk("hold_busy", ocupado, 1'b1);
      end
    end else begin
      got = 1'b0;
    end
  end

  task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] sh, input logic [31:0] res, input logic [31:0] hi,
                     input bit z, input bit c, input bit o, input bit e,
                     input int lat, input int hold);
    exp_t x;
    int   n;
    @(negedge clock);
    entrada_valida = 1'b1;
    controle_ULA   = op;
    dado_1         = a;
    dado_ULA       = b;
    shamt          = sh;
    @(posedge clock);
    #1;
    entrada_valida = 1'b0;
    dado_1         = ~a;
    dado_ULA       = a ^ b;
    shamt          = ~sh;
    x.res = res;
`ifdef ULA_HI_EN
    x.hi  = hi;
`else
    x.hi  = 32'h0;
`endif
    x.z = z; x.c = c; x.o = o; x.e = e;
    x.lat = lat;
    x.acc = cyc;
    q.push_back(x);
    n = 0;
    while (saida_valida !== 1'b1 && n < 100) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (saida_valida !== 1'b1) begin
      chk("valid_timeout", 64'd0, 64'd1);
      q.delete();
    end
    repeat (hold) begin
      @(negedge clock);
      entrada_valida = 1'b1;
      controle_ULA   = 4'b0100;
      dado_1         = 32'h1111_1111;
      dado_ULA       = 32'h2222_2222;
    end
    @(negedge clock);
    entrada_valida = 1'b0;
    saida_aceita   = 1'b1;
    @(posedge clock);
    #1;
    saida_aceita = 1'b0;
  endtask

  initial begin
    reset = 1'b0; entrada_valida = 1'b0; saida_aceita = 1'b0;
    controle_ULA = 4'h0; dado_1 = '0; dado_ULA = '0; shamt = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy",  ocupado, 1'b0);
    chk("rst_valid", saida_valida, 1'b0);
    chk("rst_res",   resultado_ULA, 32'h0);
    chk("rst_flags", {zero, cond, sobrecarga, erro_div}, 4'b0000);
    @(negedge clock);
    reset = 1'b1;

    //   op      A             B             sh     res           hi            z c o e lat hold
    run(4'b0100, 32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 32'h0,        0,0,1,0, 1, 0);
    run(4'b0110, 32'hFFFFFFFD, 32'h00000007, 5'd0,  32'hFFFFFFEB, 32'hFFFFFFFF, 0,0,0,0, 33, 0);
    run(4'b0111, 32'hFFFFFFF9, 32'h00000002, 5'd0,  32'hFFFFFFFD, 32'hFFFFFFFF, 0,0,0,0, 33, 0);
    run(4'b0111, 32'h00000005, 32'h00000000, 5'd0,  32'h0,        32'h0,        1,0,0,1, 1, 0);
    run(4'b1100, 32'h00000005, 32'h00000005, 5'd0,  32'h1,        32'h0,        0,1,0,0, 1, 0);
    run(4'b1101, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h1,        32'h0,        0,1,0,0, 1, 0);
    run(4'b1000, 32'h0000F0F0, 32'h00000FF0, 5'd0,  32'h000000F0, 32'h0,        0,0,0,0, 1, 10);
    run(4'b0111, 32'h80000000, 32'hFFFFFFFF, 5'd0,  32'h80000000, 32'h0,        0,0,1,0, 33, 0);
    run(4'b0111, 32'h00000007, 32'hFFFFFFFE, 5'd0,  32'hFFFFFFFD, 32'h00000001, 0,0,0,0, 33, 0);
    run(4'b0110, 32'h00010000, 32'h00010000, 5'd0,  32'h0,        32'h00000001, 1,0,0,0, 33, 0);
    run(4'b1110, 32'h00000001, 32'h0,        5'd31, 32'h80000000, 32'h0,        0,0,0,0, 1, 0);
    run(4'b1111, 32'h80000000, 32'h0,        5'd4,  32'hF8000000, 32'h0,        0,0,0,0, 1, 0);
    run(4'b1111, 32'h12345678, 32'h0,        5'd0,  32'h12345678, 32'h0,        0,0,0,0, 1, 0);
    run(4'b0011, 32'h00000003, 32'h00000004, 5'd0,  32'h1,        32'h0,        0,1,0,0, 1, 0);
    run(4'b0011, 32'h00000004, 32'h00000004, 5'd0,  32'h0,        32'h0,        1,0,0,0, 1, 0);
    run(4'b0000, 32'h12345678, 32'h9ABCDEF0, 5'd3,  32'h0,        32'h0,        0,0,0,0, 1, 0);
    run(4'b0101, 32'h80000000, 32'h00000001, 5'd0,  32'h7FFFFFFF, 32'h0,        0,0,1,0, 1, 0);
    run(4'b1010, 32'h00000000, 32'h0,        5'd0,  32'hFFFFFFFF, 32'h0,        0,0,0,0, 1, 0);
    run(4'b1011, 32'hFF00FF00, 32'h0FF00FF0, 5'd0,  32'hF0F0F0F0, 32'h0,        0,0,0,0, 1, 0);
    run(4'b1001, 32'hF0000000, 32'h0000000F, 5'd0,  32'hF000000F, 32'h0,        0,0,0,0, 1, 0);
    run(4'b0010, 32'h11111111, 32'hCAFEBABE, 5'd0,  32'hCAFEBABE, 32'h0,        0,0,0,0, 1, 0);

    // Abort a divide with reset partway through the iteration.
    @(negedge clock);
    entrada_valida = 1'b1;
    controle_ULA = 4'b0111; dado_1 = 32'd100; dado_ULA = 32'd3;
    @(posedge clock);
    #1;
    entrada_valida = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    chk("busy_mid_div", ocupado, 1'b1);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("abort_busy",  ocupado, 1'b0);
    chk("abort_valid", saida_valida, 1'b0);
    chk("abort_res",   resultado_ULA, 32'h0);
    chk("abort_hi",    resultado_hi, 32'h0);
    chk("abort_flags", {zero, cond, sobrecarga, erro_div}, 4'b0000);
    @(negedge clock);
    reset = 1'b1;
    run(4'b0101, 32'h00000003, 32'h00000005, 5'd0,  32'hFFFFFFFE, 32'h0,        0,0,0,0, 1, 0);

    repeat (3) @(posedge clock);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
